wb_retire_stage: RTL
====================

# wb_retire_stage

Final writeback/retire stage of the CPU pipeline, consuming the rd/result/PC/op_data bundle produced by the stage-3 pipeline register. It decodes op_data and selects writeback data (ALU result, extended load data, or PC+4). It waits on the data-memory read handshake for loads, stalling upstream, and drives a registered register-file write port, a forwarding tap and retire information.

## Interface
Parameters:
- XLEN, 32, datapath width.
- RD_W, 5, register index width.

Ports:
- clk_en  in  1  clock; gated clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input bundle valid this cycle.
- rd  in  RD_W  destination register.
- res  in  XLEN  ALU result / load address.
- PC  in  XLEN  instruction PC.
- op_data  in  11  control: [10] reg_write, [9] mem_read, [8:7] wb_sel (00 res, 01 load, 10 PC+4, 11 reserved→res), [6:4] load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU), [3:0] ignored.
- mem_rdata  in  XLEN  aligned memory read word.
- mem_rvalid  in  1  mem_rdata valid (single-cycle pulse or level).
- stall  out  1  upstream must hold its bundle (combinational).
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  RD_W  write index (registered).
- rf_wdata  out  XLEN  write data (registered).
- fwd_valid, fwd_rd, fwd_data  out  1/RD_W/XLEN  forwarding tap; mirrors rf_we/rf_waddr/rf_wdata.
- retire_valid  out  1  one-cycle pulse per retired instruction.
- retire_pc  out  XLEN  PC of retired instruction.
- instret  out  64  retired-instruction count (only with RETIRE_CNT_EN).

## Operation
- FSM states: RUN, WAIT_MEM. Reset state: RUN.
- RUN, in_valid=0: no write; rf_we=0 and retire_valid=0 next cycle.
- RUN, in_valid=1, mem_read=0: accept, retire next edge.
- RUN, in_valid=1, mem_read=1, mem_rvalid=1: accept and retire next edge with the extended mem_rdata.
- RUN, in_valid=1, mem_read=1, mem_rvalid=0: latch rd/res/PC/op_data internally, go to WAIT_MEM.
- WAIT_MEM: inputs ignored. On mem_rvalid=1, retire the latched instruction with mem_rdata and return to RUN.
- stall = (RUN & in_valid & mem_read & !mem_rvalid) | (WAIT_MEM & !mem_rvalid).
- Load extension uses byte offset res[1:0]:
  - LB/LBU select byte res[1:0].
  - LH/LHU select halfword res[1]; res[0] is ignored.
  - LW uses the whole word.
  - Signed loads sign-extend; unsigned loads zero-extend.
  - Undefined funct3 behaves as LW.
- wb_sel=10 writes PC+4, mod 2^XLEN; wrap-around is not flagged.
- rf_we = reg_write & (rd != 0). Writes to x0 are suppressed, but the instruction still retires.
- mem_read=1 with wb_sel≠01 still waits for mem_rvalid; the writeback source follows wb_sel.
- mem_rvalid in RUN with in_valid=0 is ignored.

## Timing
- Latency: retire edge = accept edge for non-loads and same-cycle-rvalid loads; otherwise the edge on which mem_rvalid=1 is sampled in WAIT_MEM.
- rf_we, rf_waddr, rf_wdata, fwd_*, retire_valid and retire_pc are registered. They update on the retire edge and hold for exactly one cycle, except the data/addr/pc values, which hold until the next retire.
- retire_valid and rf_we are 0 in every cycle without a retire.
- stall is combinational from in_valid, op_data[9], mem_rvalid and the state.
- Reset (async, mid-operation included): state→RUN; latched bundle is cleared; rf_we=0, rf_waddr=0, rf_wdata=0, fwd_*=0, retire_valid=0, retire_pc=0, instret=0; stall is then the combinational value in RUN.

## Configuration
- RETIRE_CNT_EN defined: instret is a 64-bit counter that increments by 1 on every retire edge, wraps at 2^64, and resets to 0.
- RETIRE_CNT_EN undefined: the counter is not built; the instret port is tied to 0.

## Test plan
- ALU writeback: in_valid=1, rd=5, res=0x1234, op_data reg_write=1, wb_sel=00 → next edge rf_we=1, rf_waddr=5, rf_wdata=0x1234, retire_pc=PC, retire_valid pulse; stall=0 throughout.
- x0 suppression: rd=0, reg_write=1, res=0xFFFF → rf_we=0, retire_valid=1, instret +1.
- Load with wait: LB, res=0x...02, mem_read=1, mem_rvalid low for 3 cycles then high with mem_rdata=0x0080_0000 → stall=1 for 3 cycles; then rf_wdata=0xFFFF_FF80; LBU variant gives 0x0000_0080.
- Zero-wait LHU: res[1:0]=2'b10, mem_rvalid=1 same cycle, mem_rdata=0xBEEF_0000 → no stall, rf_wdata=0x0000_BEEF.
- Link write: wb_sel=10, PC=0xFFFF_FFFC → rf_wdata=0x0000_0000.
- Reset in WAIT_MEM: assert rst low mid-wait → all outputs 0 immediately, state RUN. After release, a later mem_rvalid causes no write.

Source files
------------

// File: rtl/wb_retire_stage.sv
// rtl/wb_retire_stage.sv - writeback/retire stage: wb select, load extend, mem wait, registered rf write
// Optional retired-instruction counter built when RETIRE_CNT_EN is defined.
module wb_retire_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk_en,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [RD_W-1:0] rd,
    input  logic [XLEN-1:0] res,
    input  logic [XLEN-1:0] PC,
    input  logic [10:0]     op_data,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid,
    output logic            stall,
    output logic            rf_we,
    output logic [RD_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            fwd_valid,
    output logic [RD_W-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            retire_valid,
    output logic [XLEN-1:0] retire_pc,
    output logic [63:0]     instret
);

    typedef enum logic {RUN = 1'b0, WAIT_MEM = 1'b1} state_t;

    state_t state_q, state_d;

    // Only op_data[10:4] is meaningful; the latched copy keeps just those bits.
    logic [RD_W-1:0] lat_rd_q;
    logic [XLEN-1:0] lat_res_q;
    logic [XLEN-1:0] lat_pc_q;
    logic [6:0]      lat_op_q;

    logic            rf_we_q, rf_we_d;
    logic [RD_W-1:0] rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            retire_valid_q;
    logic [XLEN-1:0] retire_pc_q;

    logic            retire;
    logic            latch_en;
    logic [RD_W-1:0] sel_rd;
    logic [XLEN-1:0] sel_res;
    logic [XLEN-1:0] sel_pc;
    logic [6:0]      sel_op;
    logic [XLEN-1:0] load_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    logic unused_op_bits;
    assign unused_op_bits = ^op_data[3:0];

    always_ff @(posedge clk_en or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (in_valid && op_data[9] && !mem_rvalid) state_d = WAIT_MEM;
            WAIT_MEM: if (mem_rvalid) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        retire   = 1'b0;
        latch_en = 1'b0;
        sel_rd   = rd;
        sel_res  = res;
        sel_pc   = PC;
        sel_op   = op_data[10:4];
        case (state_q)
            RUN: begin
                stall    = in_valid && op_data[9] && !mem_rvalid;
                retire   = in_valid && (!op_data[9] || mem_rvalid);
                latch_en = stall;
            end
            WAIT_MEM: begin
                stall   = !mem_rvalid;
                retire  = mem_rvalid;
                sel_rd  = lat_rd_q;
                sel_res = lat_res_q;
                sel_pc  = lat_pc_q;
                sel_op  = lat_op_q;
            end
            default: ;
        endcase
    end

    // Byte/halfword lanes come from the low address bits; res[0] is ignored for halves.
    assign ld_byte = mem_rdata[{sel_res[1:0], 3'b000} +: 8];
    assign ld_half = mem_rdata[{sel_res[1], 4'b0000} +: 16];

    always_comb begin
        case (sel_op[2:0])
            3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        case (sel_op[4:3])
            2'b01:   rf_wdata_d = load_data;
            2'b10:   rf_wdata_d = sel_pc + XLEN'(4);
            default: rf_wdata_d = sel_res;
        endcase
        rf_we_d = retire && sel_op[6] && (sel_rd != '0);
    end

    always_ff @(posedge clk_en or negedge rst) begin
        if (!rst) begin
            lat_rd_q  <= '0;
            lat_res_q <= '0;
            lat_pc_q  <= '0;
            lat_op_q  <= '0;
        end else if (latch_en) begin
            lat_rd_q  <= rd;
            lat_res_q <= res;
            lat_pc_q  <= PC;
            lat_op_q  <= op_data[10:4];
        end
    end

    always_ff @(posedge clk_en or negedge rst) begin
        if (!rst) begin
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            retire_valid_q <= 1'b0;
            retire_pc_q    <= '0;
        end else begin
            rf_we_q        <= rf_we_d;
            retire_valid_q <= retire;
            if (retire) begin
                rf_waddr_q  <= sel_rd;
                rf_wdata_q  <= rf_wdata_d;
                retire_pc_q <= sel_pc;
            end
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign fwd_valid    = rf_we_q;
    assign fwd_rd       = rf_waddr_q;
    assign fwd_data     = rf_wdata_q;
    assign retire_valid = retire_valid_q;
    assign retire_pc    = retire_pc_q;

`ifdef RETIRE_CNT_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk_en or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule
